fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Sequences and shares the single write port of the 640x480 RGB111 framebuffer BRAM. The display read path owns the other port.
- Three requesters share the write port:
  - Clear/fill engine: writes one colour over the whole frame.
  - Cursor paint: writes one pixel at (x,y).
  - UART image-load stream: writes raster-order pixels starting at address 0.
- Issues at most one BRAM write per clk_50mhz cycle. Fixed priority: clear > paint > load.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame. H_RES*V_RES is the frame size; simulation shrinks both.
- ADDR_W, 19, BRAM address width. Must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk_50mhz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clear_req  in  1  1-cycle pulse: start a full-frame fill.
- clear_color  in  3  RGB fill colour, sampled when clear_req is accepted.
- busy  out  1  high while a fill is in progress.
- paint_req  in  1  level; held high until paint_ack.
- paint_x  in  10  paint column.
- paint_y  in  10  paint row.
- paint_color  in  3  RGB colour for the paint pixel.
- paint_ack  out  1  1-cycle pulse: paint request consumed.
- load_start  in  1  1-cycle pulse: arm the stream at address 0.
- load_valid  in  1  stream pixel valid.
- load_data  in  8  stream pixel; only bits [2:0] are used.
- load_ready  out  1  stream may transfer this cycle.
- load_done  out  1  1-cycle pulse: last frame pixel written.
- bram_we  out  1  write enable.
- bram_waddr  out  ADDR_W  write address.
- bram_wdata  out  8  write data, format 00000RGB.

Behaviour:
- Reset: state IDLE, load_active=0, load pointer=0, fill pointer=0.
  - All outputs 0, except load_ready, which is 0 because load_active=0.
- FSM states: IDLE and CLEAR.
- IDLE to CLEAR: clear_req=1 in IDLE.
  - Latch clear_color and set fill pointer to 0.
  - busy rises the next cycle.
- CLEAR:
  - Each cycle writes fill pointer with {5'b0, latched colour}, then increments the pointer.
  - After the write at H_RES*V_RES-1, return to IDLE; busy falls the cycle after that write.
  - clear_req during CLEAR is ignored; no restart and no queueing.
- Paint is accepted in IDLE when paint_req=1 and clear_req=0.
  - paint_ack pulses for exactly one cycle; paint_req must drop before the next request.
  - Address = paint_y*H_RES + paint_x. For the default H_RES this is computed as (y<<9)+(y<<7)+x, zero-extended to ADDR_W.
  - If paint_x>=H_RES or paint_y>=V_RES: paint_ack still pulses, but no write is issued.
  - paint_req during CLEAR waits, with no ack, until the fill completes.
- load_ready (combinational) = IDLE && load_active && !clear_req && !paint_req && !load_start.
- Load transfer = load_valid && load_ready.
  - Writes the load pointer with {5'b0, load_data[2:0]}, then increments the pointer.
  - The transfer at pointer H_RES*V_RES-1 clears load_active. load_done pulses in the same cycle as that write.
- load_start:
  - Sets load_active=1 and load pointer=0 in any state. If issued mid-stream it restarts the stream.
  - If issued during CLEAR, the fill continues and the stream waits.
- Transfers attempted while load_active=0 are not accepted (load_ready=0) and have no effect.
- Write latency:
  - A grant at edge N drives bram_we/addr/data registered during cycle N+1.
  - bram_we=1 for exactly one cycle per write; otherwise bram_we=0 and address/data hold their last values.
- Simultaneous events:
  - Clear preempts pending paint and load; the load pointer is preserved.
  - Paint preempts load for one cycle; the stream resumes on the next cycle without losing its pointer.
- Reset mid-operation aborts any fill or stream immediately; no further writes are issued.

Test Plan:
- H_RES=8, V_RES=4. clear_req with clear_color=3'b101 -> 32 consecutive writes, addr 0..31, data 8'h05. busy is high for 32 cycles, then low.
- Paint (x=3, y=2, colour 3'b010) in IDLE -> one write, addr 19, data 8'h02, paint_ack 1 cycle. Paint (x=8, y=0) -> ack, no write.
- load_start, then 32 pixels 8'hF0..8'hFF,8'h00.. with load_valid continuous -> writes to addr 0..31, data = byte&8'h07. load_done pulses with the addr-31 write; load_ready=0 afterwards.
- Streaming load; paint_req at stream pixel 10 -> load_ready low 1 cycle, paint write issued, stream resumes at addr 10 with no gap or duplicate.
- clear_req at stream pixel 5 -> fill of 32 writes completes, then the stream resumes at addr 5. A paint_req held during the fill is acked only after busy falls.
- Reset asserted on fill cycle 7 -> bram_we=0 from the next cycle, busy=0, load_ready=0. load_start after reset restarts the stream at addr 0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// ============================================================================
//  Module   : fb_write_arbiter
//  Purpose  : Fixed-priority sharing of the framebuffer BRAM write port
//             (clear/fill > cursor paint > UART image-load stream).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_arbiter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [2:0]        clear_color,
    output logic              busy,
    input  logic              paint_req,
    input  logic [9:0]        paint_x,
    input  logic [9:0]        paint_y,
    input  logic [2:0]        paint_color,
    output logic              paint_ack,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [7:0]        bram_wdata
);

    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [31:0]       H_LIM    = 32'(H_RES);
    localparam logic [31:0]       V_LIM    = 32'(V_RES);

    logic [0:0]        state_q,       state_d;
    logic [2:0]        color_q,       color_d;
    logic [ADDR_W-1:0] fill_ptr_q,    fill_ptr_d;
    logic              load_active_q, load_active_d;
    logic [ADDR_W-1:0] load_ptr_q,    load_ptr_d;
    logic              we_q,          we_d;
    logic [ADDR_W-1:0] waddr_q,       waddr_d;
    logic [7:0]        wdata_q,       wdata_d;
    logic              load_done_q,   load_done_d;

    logic [ADDR_W-1:0] paint_addr;
    logic              paint_in_range;
    logic              load_xfer;
    logic              unused_load_bits;

    assign unused_load_bits = ^load_data[7:3];

    // 640 = 512 + 128, so the full-size build needs no multiplier.
    if (H_RES == 640) begin : g_addr_shift
        assign paint_addr = (ADDR_W'(paint_y) << 9) + (ADDR_W'(paint_y) << 7)
                          + ADDR_W'(paint_x);
    end else begin : g_addr_mul
        assign paint_addr = ADDR_W'(paint_y) * ADDR_W'(H_RES) + ADDR_W'(paint_x);
    end

    assign paint_in_range = (32'(paint_x) < H_LIM) && (32'(paint_y) < V_LIM);

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            color_q       <= '0;
            fill_ptr_q    <= '0;
            load_active_q <= 1'b0;
            load_ptr_q    <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            color_q       <= color_d;
            fill_ptr_q    <= fill_ptr_d;
            load_active_q <= load_active_d;
            load_ptr_q    <= load_ptr_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            load_done_q   <= load_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        color_d       = color_q;
        fill_ptr_d    = fill_ptr_q;
        load_active_d = load_active_q;
        load_ptr_d    = load_ptr_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        load_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    color_d    = clear_color;
                    fill_ptr_d = '0;
                end else if (paint_ack) begin
                    // Off-screen paints are acknowledged but dropped.
                    if (paint_in_range) begin
                        we_d    = 1'b1;
                        waddr_d = paint_addr;
                        wdata_d = {5'b0, paint_color};
                    end
                end else if (load_xfer) begin
                    we_d       = 1'b1;
                    waddr_d    = load_ptr_q;
                    wdata_d    = {5'b0, load_data[2:0]};
                    load_ptr_d = load_ptr_q + ADDR_W'(1);
                    if (load_ptr_q == LAST_PIX) begin
                        load_active_d = 1'b0;
                        load_done_d   = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                we_d       = 1'b1;
                waddr_d    = fill_ptr_q;
                wdata_d    = {5'b0, color_q};
                fill_ptr_d = fill_ptr_q + ADDR_W'(1);
                if (fill_ptr_q == LAST_PIX) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A restart wins over any pointer update from this cycle's transfer.
        if (load_start) begin
            load_active_d = 1'b1;
            load_ptr_d    = '0;
        end
    end

    always_comb begin
        busy       = (state_q == ST_CLEAR);
        paint_ack  = (state_q == ST_IDLE) && paint_req && !clear_req;
        load_ready = (state_q == ST_IDLE) && load_active_q && !clear_req
                   && !paint_req && !load_start;
        load_xfer  = load_valid && load_ready;
    end

    assign bram_we    = we_q;
    assign bram_waddr = waddr_q;
    assign bram_wdata = wdata_q;
    assign load_done  = load_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
// ============================================================================
//  Module   : tb_fb_write_arbiter
//  Purpose  : Scoreboard bench for fb_write_arbiter on an 8x4 frame.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_write_arbiter;

    localparam int H = 8;
    localparam int V = 4;
    localparam int AW = 5;
    localparam int NPIX = H * V;

    logic          clk_50mhz = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic [2:0]    clear_color = '0;
    logic          busy;
    logic          paint_req = 1'b0;
    logic [9:0]    paint_x = '0;
    logic [9:0]    paint_y = '0;
    logic [2:0]    paint_color = '0;
    logic          paint_ack;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_data = '0;
    logic          load_ready;
    logic          load_done;
    logic          bram_we;
    logic [AW-1:0] bram_waddr;
    logic [7:0]    bram_wdata;

    fb_write_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_color(clear_color),
        .busy       (busy),
        .paint_req  (paint_req),
        .paint_x    (paint_x),
        .paint_y    (paint_y),
        .paint_color(paint_color),
        .paint_ack  (paint_ack),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .bram_we    (bram_we),
        .bram_waddr (bram_waddr),
        .bram_wdata (bram_wdata)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wr_cnt   = 0;
    int  ld_cnt   = 0;
    int  ld_addr  = -1;
    int  ld_we    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    // Every observed write must match the head of the expected-write queue.
    always @(negedge clk_50mhz) begin
        if (load_done) begin
            ld_cnt++;
            ld_addr = 32'(bram_waddr);
            ld_we   = 32'(bram_we);
        end
        if (bram_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_write_queue", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bram_waddr), e.addr);
                check("wr_data", 32'(bram_wdata), e.data);
            end
        end
    end

    // Drives a 32-pixel stream (bytes F0+idx), optionally injecting a clear
    // and/or a held paint request when the stream reaches given indices.
    task automatic run_stream(input int clear_at, input logic [2:0] ccol,
                              input int paint_at, input int px, input int py,
                              input logic [2:0] pcol,
                              output int stalls, output int acks,
                              output int ack_busy, output int done_idx);
        int idx = 0;
        int cyc = 0;
        bit cinj = 0;
        bit pinj = 0;
        bit rdy, pack;
        stalls = 0; acks = 0; ack_busy = 0;
        while (idx < NPIX && cyc < 300) begin
            load_valid = 1'b1;
            load_data  = 8'hF0 + 8'(idx);
            clear_req  = 1'b0;
            if (!cinj && idx == clear_at) begin
                clear_req   = 1'b1;
                clear_color = ccol;
                cinj        = 1;
            end
            if (!pinj && idx == paint_at && !clear_req) begin
                paint_req   = 1'b1;
                paint_x     = 10'(px);
                paint_y     = 10'(py);
                paint_color = pcol;
                pinj        = 1;
            end
            @(negedge clk_50mhz);
            rdy  = load_ready;
            pack = paint_ack;
            if (!rdy) stalls++;
            if (pack) begin
                acks++;
                if (busy) ack_busy++;
            end
            tick();
            if (rdy) idx++;
            if (pack) paint_req = 1'b0;
            cyc++;
        end
        load_valid = 1'b0;
        clear_req  = 1'b0;
        paint_req  = 1'b0;
        done_idx   = idx;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
        @(negedge clk_50mhz);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, w0, stalls, acks, ack_busy, didx;

        // Reset state
        repeat (3) tick();
        @(negedge clk_50mhz);
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(bram_we), 0);
        check("rst_ready", 32'(load_ready), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_waddr", 32'(bram_waddr), 0);
        check("rst_wdata", 32'(bram_wdata), 0);
        tick();
        reset = 1'b0;
        tick();

        // Full-frame fill
        for (int i = 0; i < NPIX; i++) push_wr(i, 5);
        w0 = wr_cnt;
        clear_req = 1'b1;
        clear_color = 3'b101;
        @(negedge clk_50mhz);
        check("busy_before_fill", 32'(busy), 0);
        tick();
        clear_req = 1'b0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50mhz);
            if (busy) bc++;
        end
        check("fill_busy_cycles", bc, NPIX);
        check("fill_write_count", wr_cnt - w0, NPIX);
        drain(1);

        // In-range paint
        push_wr(19, 2);
        tick();
        paint_req = 1'b1; paint_x = 10'd3; paint_y = 10'd2; paint_color = 3'b010;
        @(negedge clk_50mhz);
        check("paint_ack", 32'(paint_ack), 1);
        tick();
        paint_req = 1'b0;
        drain(3);

        // Off-screen paint: ack without write
        w0 = wr_cnt;
        paint_req = 1'b1; paint_x = 10'd8; paint_y = 10'd0; paint_color = 3'b111;
        @(negedge clk_50mhz);
        check("oob_paint_ack", 32'(paint_ack), 1);
        tick();
        paint_req = 1'b0;
        repeat (3) tick();
        check("oob_paint_no_write", wr_cnt - w0, 0);

        // Plain stream load
        ld_cnt = 0;
        for (int i = 0; i < NPIX; i++) push_wr(i, (8'hF0 + i) & 7);
        pulse_load_start();
        run_stream(-1, 3'b000, -1, 0, 0, 3'b000, stalls, acks, ack_busy, didx);
        check("load_idx", didx, NPIX);
        check("load_stalls", stalls, 0);
        drain(2);
        check("load_done_count", ld_cnt, 1);
        check("load_done_addr", ld_addr, NPIX - 1);
        check("load_done_with_we", ld_we, 1);
        check("ready_after_done", 32'(load_ready), 0);

        // Transfers with the stream inactive are ignored
        w0 = wr_cnt;
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50mhz);
            check("ready_inactive", 32'(load_ready), 0);
            tick();
        end
        load_valid = 1'b0;
        check("inactive_no_write", wr_cnt - w0, 0);

        // Paint interrupting a stream at pixel 10
        for (int i = 0; i < 10; i++) push_wr(i, i & 7);
        push_wr(9, 7);
        for (int i = 10; i < NPIX; i++) push_wr(i, i & 7);
        pulse_load_start();
        run_stream(-1, 3'b000, 10, 1, 1, 3'b111, stalls, acks, ack_busy, didx);
        check("pstream_idx", didx, NPIX);
        check("pstream_stalls", stalls, 1);
        check("pstream_acks", acks, 1);
        drain(2);

        // Clear at pixel 5 with a paint held through the fill
        for (int i = 0; i < 5; i++) push_wr(i, i & 7);
        for (int i = 0; i < NPIX; i++) push_wr(i, 3);
        push_wr(26, 1);
        for (int i = 5; i < NPIX; i++) push_wr(i, i & 7);
        pulse_load_start();
        run_stream(5, 3'b011, 5, 2, 3, 3'b001, stalls, acks, ack_busy, didx);
        check("cstream_idx", didx, NPIX);
        check("cstream_stalls", stalls, NPIX + 2);
        check("cstream_acks", acks, 1);
        check("cstream_ack_during_busy", ack_busy, 0);
        drain(2);

        // Reset during fill cycle 7, stream armed meanwhile
        for (int i = 0; i < 6; i++) push_wr(i, 6);
        clear_req = 1'b1;
        clear_color = 3'b110;
        tick();
        clear_req = 1'b0;
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clk_50mhz);
        check("pre_reset_busy", 32'(busy), 1);
        tick();
        @(negedge clk_50mhz);
        check("post_reset_we", 32'(bram_we), 0);
        check("post_reset_busy", 32'(busy), 0);
        check("post_reset_ready", 32'(load_ready), 0);
        tick();
        reset = 1'b0;
        drain(4);
        for (int i = 0; i < NPIX; i++) push_wr(i, i & 7);
        pulse_load_start();
        run_stream(-1, 3'b000, -1, 0, 0, 3'b000, stalls, acks, ack_busy, didx);
        check("restart_idx", didx, NPIX);
        drain(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
